// File: rtl/cfu_resp_tracker_pkg.sv
// cfu_types: shared CFU tracker types and defaults
package cfu_types;
  typedef enum logic [1:0] {NONE, SPURIOUS, OVERFLOW} cfu_resp_tracker_err_t;
  localparam int CFU_ID_WIDTH = 4;
endpackage

// File: rtl/cfu_sync_fifo.sv
// cfu_sync_fifo: synchronous FIFO with wrap-bit pointers, modulo-DEPTH indexing
module cfu_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wi, ri;
  logic ww, rw, do_push, do_pop;
  assign empty = (wi == ri) && (ww == rw);
  assign full = (wi == ri) && (ww != rw);
  assign do_pop = pop & ~empty;
  // a same-cycle pop frees the slot the push needs when full
  assign do_push = push & (~full | do_pop);
  assign dout = mem[ri];
  assign count = full ? CW'(DEPTH) : CW'((ww == rw) ? int'(wi) - int'(ri) : DEPTH + int'(wi) - int'(ri));
  always_ff @(posedge clk)
    if (do_push) mem[wi] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wi <= '0;
      ri <= '0;
      ww <= 1'b0;
      rw <= 1'b0;
    end else begin
      if (do_push) begin
        wi <= (wi == AW'(DEPTH-1)) ? '0 : wi + 1'b1;
        ww <= (wi == AW'(DEPTH-1)) ? ~ww : ww;
      end
      if (do_pop) begin
        ri <= (ri == AW'(DEPTH-1)) ? '0 : ri + 1'b1;
        rw <= (ri == AW'(DEPTH-1)) ? ~rw : rw;
      end
    end
  end
endmodule

// File: rtl/cfu_resp_tracker.sv
// cfu_resp_tracker: credit-gated CFU request tracking with in-order buffered responses
module cfu_resp_tracker
  import cfu_types::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH = CFU_ID_WIDTH,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W = $clog2(MAX_OUTSTANDING+1)
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  output logic req_ready,
  input  logic [ID_WIDTH-1:0] req_id,
  output logic acc_req_valid,
  input  logic acc_req_ready,
  input  logic acc_resp_valid,
  input  logic [DATA_WIDTH-1:0] acc_resp_data,
  output logic resp_valid,
  input  logic resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [ID_WIDTH-1:0] resp_id,
  output logic [CNT_W-1:0] outstanding,
  output logic err
);
  cfu_resp_tracker_err_t err_kind;
  logic can_issue, accept, pop, rsp_push, id_full, id_empty, rsp_full, rsp_empty, unused_id_empty;
  logic [CNT_W-1:0] rsp_count;
  // the ID FIFO occupancy is the outstanding-credit count
  assign can_issue = ~id_full;
  assign req_ready = acc_req_ready & can_issue & ~rst;
  assign acc_req_valid = req_valid & can_issue & ~rst;
  assign accept = req_valid & req_ready;
  assign resp_valid = ~rsp_empty;
  assign pop = resp_valid & resp_ready;
  assign unused_id_empty = id_empty;
  always_comb
    err_kind = ~acc_resp_valid ? NONE :
               (rsp_full & ~pop) ? OVERFLOW :
               (rsp_count == outstanding) ? SPURIOUS : NONE;
  assign rsp_push = acc_resp_valid & (err_kind == NONE);
  always_ff @(posedge clk)
    err <= rst ? 1'b0 : (err | (err_kind != NONE));
  cfu_sync_fifo #(.DATA_WIDTH(ID_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_id_fifo (
    .clk(clk), .rst(rst), .push(accept), .din(req_id), .pop(pop),
    .dout(resp_id), .full(id_full), .empty(id_empty), .count(outstanding)
  );
  cfu_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_rsp_fifo (
    .clk(clk), .rst(rst), .push(rsp_push), .din(acc_resp_data), .pop(pop),
    .dout(resp_data), .full(rsp_full), .empty(rsp_empty), .count(rsp_count)
  );
endmodule

// File: doc/cfu_resp_tracker.md
Name: cfu_resp_tracker

Overview:
- Tracks CFU transaction state between the core-side CFU handshake and a vector/custom accelerator whose result strobe has no backpressure.
- Holds up to MAX_OUTSTANDING in-flight request IDs and buffers results in a response FIFO, so a stalled resp_ready never overwrites data.
- Gates request acceptance with an outstanding-credit counter and returns responses in order with their IDs.
- Sits between cfu_interface and accelerator cores such as the vector unit.

Parameters:
- DATA_WIDTH, 32, width of response data.
- ID_WIDTH, 4, width of the CFU request/response ID.
- MAX_OUTSTANDING, 4, maximum accepted-but-unreturned requests; also the depth of the ID FIFO and the response FIFO; legal range 1..64.
- CNT_W, $clog2(MAX_OUTSTANDING+1), derived width of the credit counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  core request accepted this cycle when high with req_valid
- req_id  in  ID_WIDTH  core request ID
- acc_req_valid  out  1  request forwarded to accelerator
- acc_req_ready  in  1  accelerator able to take a request
- acc_resp_valid  in  1  one-cycle result strobe from accelerator; no backpressure
- acc_resp_data  in  DATA_WIDTH  accelerator result
- resp_valid  out  1  response available to core
- resp_ready  in  1  core consumes response
- resp_data  out  DATA_WIDTH  response data, head of response FIFO
- resp_id  out  ID_WIDTH  ID of oldest outstanding request
- outstanding  out  CNT_W  current credit count
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset (clk edge with rst=1), all outputs:
  - req_ready=0, acc_req_valid=0, resp_valid=0, outstanding=0, err=0.
  - resp_data and resp_id are don't-care; both FIFOs are emptied.
- Credit gate: can_issue = (outstanding < MAX_OUTSTANDING), from the registered count only. A pop in the same cycle does not free a credit (no bypass).
- Request path is combinational:
  - req_ready = acc_req_ready & can_issue & ~rst.
  - acc_req_valid = req_valid & can_issue & ~rst.
  - accept = req_valid & req_ready.
- On accept, req_id is pushed into the ID FIFO.
- On acc_resp_valid, acc_resp_data is pushed into the response FIFO.
- Response latency: resp_valid rises the cycle after the acc_resp_valid strobe (registered FIFO, no fall-through).
- Output: resp_valid = response FIFO non-empty. resp_data = response FIFO head. resp_id = ID FIFO head.
- Pop: pop = resp_valid & resp_ready. It pops both FIFOs in the same cycle.
- Counter:
  - outstanding += accept, -= pop.
  - accept and pop together: count unchanged.
  - Count never exceeds MAX_OUTSTANDING and never goes below 0.
- resp_valid/resp_data/resp_id hold stable while resp_valid=1 and resp_ready=0.
- Error conditions: err is set when either of the following occurs, and stays set until rst:
  - acc_resp_valid while response FIFO occupancy already equals the number of IDs in flight (spurious result, including one with nothing outstanding). The spurious push is dropped.
  - Response FIFO full on push.
- FIFO wrap-around: pointers are modulo MAX_OUTSTANDING with an extra wrap bit; full/empty are derived from pointer equality and the wrap bit.
- Reset mid-operation: all in-flight IDs and data are discarded. The accelerator shares rst, so no stale strobes are expected. A strobe after reset with no outstanding request sets err.
- Simultaneous push and pop on either FIFO, when full or empty, is defined:
  - Pop on empty is impossible by construction.
  - Push and pop together when full is legal for the response FIFO, since the pop frees a slot in the same cycle.

Decomposition:
- cfu_types package holds:
  - the cfu_resp_tracker_err_t enum (NONE, SPURIOUS, OVERFLOW) for debug encoding;
  - the default ID width constant.
- One sub-module: cfu_sync_fifo (parameters DATA_WIDTH, DEPTH), registered output, push/pop/full/empty/count. It is instantiated twice, once for IDs and once for data.

Test Plan:
- Single transaction, ID=3: req_valid with acc_req_ready=1 gives req_ready=1 and outstanding 0→1. acc_resp_valid with data 0xDEADBEEF two cycles later → next cycle resp_valid=1, resp_data=0xDEADBEEF, resp_id=3. With resp_ready=1, outstanding returns to 0.
- Credit stall, MAX_OUTSTANDING=4: issue IDs 1,2,3,4 back-to-back with no responses. Fifth request sees req_ready=0 and acc_req_valid=0 with outstanding=4. One pop → req_ready=1 the following cycle, not the same cycle.
- Core backpressure: 4 results strobed on consecutive cycles with resp_ready=0 → all buffered, resp_data holds the first value. Then resp_ready=1 drains in order with IDs matching issue order, and err stays 0.
- Simultaneous accept and pop at outstanding=2 → outstanding stays 2, and FIFO order is preserved across the pointer wrap (run 10 transactions through depth 4).
- Spurious strobe: acc_resp_valid with outstanding=0 → err=1 and resp_valid stays 0. err stays set until rst.
- Reset mid-flight: 3 outstanding plus 1 buffered result, then rst for one cycle → outstanding=0, resp_valid=0, req_ready follows acc_req_ready on the next cycle.
